// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative MIPS-style multiply/divide unit with HI/LO registers
//
// MULT/MULTU use shift-add, one multiplier bit per cycle, and leave the full
// 2*WIDTH-bit product in {hi,lo}. DIV/DIVU use restoring division, one
// quotient bit per cycle, and leave the quotient in lo and the remainder in
// hi. Each operation spends exactly WIDTH cycles in CALC. A divide by zero
// skips the iteration entirely. MTHI/MTLO write hi/lo directly while idle.
//
// Configuration macro:
//   MULDIV_SIGNED_EN  defined   : MULT/DIV are signed (magnitudes iterate,
//                                 sign fixed up on the final edge)
//                     undefined : MULT runs as MULTU, DIV runs as DIVU
//
// Parameters:
//   WIDTH  operand / HI / LO width (minimum 4)
//   CNT_W  iteration counter width (at least clog2(WIDTH)+1)
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   in0       multiplicand / dividend / MTHI-MTLO source
//   in1       multiplier / divisor
//   op        MIPS funct code (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   start     request, op/in0/in1 sampled on the accepting edge
//   abort     cancels the operation in flight, wins over start
//   busy      high while an operation is computing
//   done      one-cycle pulse: hi/lo hold a fresh MULT/DIV result
//   div_zero  set by a DIV/DIVU with in1 = 0, cleared by the next MULT/DIV
//   hi, lo    architectural HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [5:0]       op,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;   // running partial product / remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] opb;      // multiplicand or divisor magnitude
    logic             is_div;

    logic op_mul;
    logic op_div;
    logic last;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        op_mul = (op == OP_MULT) || (op == OP_MULTU);
        op_div = (op == OP_DIV)  || (op == OP_DIVU);
        last   = (cnt == CNT_W'(WIDTH - 1));
    end

`ifdef MULDIV_SIGNED_EN
    logic op_signed;
    logic a_neg;
    logic b_neg;
    logic neg_lo;   // product sign (MULT) or quotient sign (DIV)
    logic neg_hi;   // remainder sign, follows the dividend

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = op_signed && in0[WIDTH-1];
        b_neg     = op_signed && in1[WIDTH-1];
        // The most-negative value maps onto itself, which read unsigned is
        // exactly its magnitude, so no extra bit is needed.
        a_mag     = a_neg ? -in0 : in0;
        b_mag     = b_neg ? -in1 : in1;
    end
`else
    always_comb begin
        a_mag = in0;
        b_mag = in1;
    end
`endif

    // One iteration of either algorithm, plus the final sign fix-up.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

    // NOTE: every signal driven here gets a value on every path before any
    // conditional override, so no latch can be inferred.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b0, opb};
        div_ok    = !div_diff[WIDTH+1];

        if (is_div) begin
            // Remainder stays below the divisor, so WIDTH bits always hold it.
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end

        fin_hi = step_hi;
        fin_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            fin_lo = neg_lo ? -step_lo : step_lo;
            fin_hi = neg_hi ? -step_hi : step_hi;
        end else if (neg_lo) begin
            {fin_hi, fin_lo} = -{step_hi, step_lo};
        end
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too; they are few and
            // a known value keeps reset behaviour fully deterministic.
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (op_mul || (op_div && (in1 != '0))) begin
                            state    <= CALC;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                            is_div   <= op_div;
                            acc_hi   <= '0;
                            acc_lo   <= op_div ? a_mag : b_mag;
                            opb      <= op_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
                            neg_lo   <= a_neg ^ b_neg;
                            neg_hi   <= a_neg;
`endif
                        end else if (op_div) begin
                            // Divide by zero: answer at once, no iteration.
                            hi       <= in0;
                            lo       <= '1;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else if (op == OP_MTHI) begin
                            hi <= in0;
                        end else if (op == OP_MTLO) begin
                            lo <= in0;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CNT_W'(1);
                        if (last) begin
                            hi    <= fin_hi;
                            lo    <= fin_lo;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit (WIDTH = 32)
//
// A transaction-level model computes results with plain integer arithmetic
// and tracks when they must appear; a compare process checks busy, done,
// div_zero, hi and lo against it on every falling edge. Directed vectors add
// hand-computed literal expectations. Works with or without MULDIV_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic [W-1:0] in0   = '0;
    logic [W-1:0] in1   = '0;
    logic [5:0]   op    = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .in0      (in0),
        .in1      (in1),
        .op       (op),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] model_result(input logic [5:0] o,
                                                    input logic [W-1:0] a,
                                                    input logic [W-1:0] b);
        logic           sgn;
        longint         sa;
        longint         sb;
        longint         sq;
        longint         sr;
        logic [2*W-1:0] res;
        sgn = SIGNED_EN && ((o == OP_MULT) || (o == OP_DIV));
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if ((o == OP_MULT) || (o == OP_MULTU)) begin
            if (sgn) res = sa * sb;
            else     res = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else if (sgn) begin
            sq  = sa / sb;
            sr  = sa % sb;
            res = {sr[W-1:0], sq[W-1:0]};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] p_hi;
    logic [W-1:0] p_lo;
    logic         m_done;
    logic         m_dz;
    int           m_rem;   // cycles until the pending result lands

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                if (abort) begin
                    m_rem <= 0;
                end else if (m_rem == 1) begin
                    m_rem  <= 0;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (start && !abort) begin
                if (((op == OP_DIV) || (op == OP_DIVU)) && (in1 == '0)) begin
                    m_hi   <= in0;
                    m_lo   <= '1;
                    m_dz   <= 1'b1;
                    m_done <= 1'b1;
                end else if ((op == OP_MULT) || (op == OP_MULTU) ||
                             (op == OP_DIV)  || (op == OP_DIVU)) begin
                    {p_hi, p_lo} <= model_result(op, in0, in1);
                    m_dz         <= 1'b0;
                    m_rem        <= W;
                end else if (op == OP_MTHI) begin
                    m_hi <= in0;
                end else if (op == OP_MTLO) begin
                    m_lo <= in0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("cyc_busy",     busy,     m_rem > 0);
        check("cyc_done",     done,     m_done);
        check("cyc_div_zero", div_zero, m_dz);
        check("cyc_hi",       hi,       m_hi);
        check("cyc_lo",       lo,       m_lo);
    end

    // ---------------- stimulus helpers ----------------
    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic issue(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        in0   = a;
        in1   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the result must depend only on the latched values.
        op    = OP_MTLO;
        in0   = $urandom;
        in1   = $urandom;
    endtask

    // cycles counts the accept cycle as 1; busy_n counts samples with busy high.
    task automatic wait_done(output int cycles, output int busy_n);
        cycles = 1;
        busy_n = 0;
        while ((done !== 1'b1) && (cycles < 100)) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            cycles++;
        end
        check("done_seen", done, 1'b1);
    endtask

    int           lat;
    int           bn;
    int           t0;
    int           t1;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz",   div_zero, 1'b0);
        check("rst_hi",   hi, 32'h0);
        check("rst_lo",   lo, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // MULTU max x max: latency and busy length
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_accept", busy, 1'b1);
        wait_done(lat, bn);
        check("multu_latency", lat, 33);
        check("multu_busy_len", bn, 32);
        check("multu_busy_in_done", busy, 1'b0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // MULT -3 x 5
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bn);
`ifdef MULDIV_SIGNED_EN
        e_hi = 32'hFFFF_FFFF;
`else
        e_hi = 32'h0000_0004;
`endif
        check("mult_neg_hi", hi, e_hi);
        check("mult_neg_lo", lo, 32'hFFFF_FFF1);

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bn);
`ifdef MULDIV_SIGNED_EN
        e_hi = 32'hFFFF_FFFF; e_lo = 32'hFFFF_FFFD;
`else
        e_hi = 32'h0000_0001; e_lo = 32'h7FFF_FFFC;
`endif
        check("div_neg_hi", hi, e_hi);
        check("div_neg_lo", lo, e_lo);

        // DIV most-negative / -1
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bn);
`ifdef MULDIV_SIGNED_EN
        e_hi = 32'h0; e_lo = 32'h8000_0000;
`else
        e_hi = 32'h8000_0000; e_lo = 32'h0;
`endif
        check("div_min_hi", hi, e_hi);
        check("div_min_lo", lo, e_lo);
        check("div_min_dz", div_zero, 1'b0);

        // DIVU by zero, then MULTU issued in the done cycle
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(lat, bn);
        check("dz_latency", lat, 1);
        check("dz_busy", busy, 1'b0);
        check("dz_hi", hi, 32'd7);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_flag", div_zero, 1'b1);
        issue(OP_MULTU, 32'd2, 32'd3);
        check("dz_cleared", div_zero, 1'b0);
        wait_done(lat, bn);
        check("after_dz_lo", lo, 32'd6);
        check("after_dz_hi", hi, 32'd0);

        // MTHI, then DIV 7 / -2
        issue(OP_MTHI, 32'h0000_CAFE, 32'd0);
        check("mthi_hi", hi, 32'h0000_CAFE);
        check("mthi_busy", busy, 1'b0);
        check("mthi_done", done, 1'b0);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bn);
`ifdef MULDIV_SIGNED_EN
        e_hi = 32'd1; e_lo = 32'hFFFF_FFFD;
`else
        e_hi = 32'd7; e_lo = 32'd0;
`endif
        check("div_negb_hi", hi, e_hi);
        check("div_negb_lo", lo, e_lo);

        // MULT min x min (same in both builds)
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat, bn);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0);

        // unlisted op is a no-op
        issue(6'b000000, 32'h1111_1111, 32'h2222_2222);
        check("nop_busy", busy, 1'b0);
        check("nop_hi", hi, 32'h4000_0000);

        // abort mid-CALC, with starts presented while busy
        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        check("mtlo_lo", lo, 32'h0000_1234);
        issue(OP_MULT, 32'd5, 32'd7);
        op = OP_MTLO; in0 = 32'h0000_DEAD; start = 1'b1;
        @(negedge clk);
        op = OP_DIVU; in0 = 32'd9; in1 = 32'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_lo", lo, 32'h0000_1234);
        repeat (40) @(negedge clk);
        check("abort_lo_later", lo, 32'h0000_1234);
        abort = 1'b1;                       // abort while idle: no effect
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 1'b0);

        // back-to-back operations issued in done cycles
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done(lat, bn);
        t0 = cyc;
        check("b2b1_lo", lo, 32'd12);
        issue(OP_MULTU, 32'd10, 32'd11);
        wait_done(lat, bn);
        t1 = cyc;
        check("b2b_interval1", t1 - t0, 33);
        check("b2b2_lo", lo, 32'd110);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, bn);
        t0 = cyc;
        check("b2b_interval2", t0 - t1, 33);
        check("b2b3_lo", lo, 32'd14);
        check("b2b3_hi", hi, 32'd2);

        // reset mid-CALC, restart on the first edge after release
        issue(OP_MULTU, 32'd5, 32'd5);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_dz",   div_zero, 1'b0);
        check("midrst_hi",   hi, 32'h0);
        check("midrst_lo",   lo, 32'h0);
        @(negedge clk);
        #2;
        rst   = 1'b0;
        op    = OP_MULTU;
        in0   = 32'd6;
        in1   = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_accept", busy, 1'b1);
        wait_done(lat, bn);
        check("post_rst_latency", lat, 33);
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_hi", hi, 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width, minimum 4.
REQ-002 SHALL have parameter CNT_W, default 6: iteration counter width, at least clog2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in0  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
REQ-006 SHALL have port in1  input  WIDTH  multiplier / divisor.
REQ-007 SHALL have port op  input  6  MIPS funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
REQ-008 SHALL have port start  input  1  request; op, in0, in1 sampled on the accepting edge.
REQ-009 SHALL have port abort  input  1  cancels the operation in flight.
REQ-010 SHALL have port busy  output  1  high while an operation is computing.
REQ-011 SHALL have port done  output  1  one-cycle pulse: hi/lo hold a fresh MULT/DIV result.
REQ-012 SHALL have port div_zero  output  1  registered; set by a DIV/DIVU with in1 = 0.
REQ-013 SHALL have ports hi and lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 SHALL implement states IDLE and CALC; CALC lasts exactly WIDTH cycles, tracked by the iteration counter.
REQ-015 SHALL accept start only in IDLE with busy=0; start while busy SHALL be ignored, with no queuing.
REQ-016 SHALL latch operands on the accepting edge; later changes on in0/in1/op SHALL NOT affect the result.
REQ-017 SHALL handle MULT/MULTU as iterative shift-add, one multiplier bit per cycle; {hi,lo} = full 2*WIDTH-bit product.
REQ-018 SHALL handle DIV/DIVU as restoring division, one quotient bit per cycle; lo = quotient, hi = remainder.
REQ-019 SHALL compute signed ops on magnitudes; sign correction SHALL be applied on the final edge.
REQ-020 SHALL truncate signed quotients toward zero; the remainder SHALL take the dividend's sign.
REQ-021 SHALL produce, for the most-negative dividend / -1: lo = most-negative value, hi = 0, no exception.
REQ-022 SHALL NOT iterate on divide by zero: accept edge goes straight to done next cycle, hi = in0, lo = all ones, div_zero = 1.
REQ-023 SHALL clear div_zero at the next accepted MULT/DIV.
REQ-024 SHALL write hi/lo, pulse done and return to IDLE on the edge ending the last CALC cycle; busy SHALL be 0 during the done cycle.
REQ-025 SHALL give latency: accept at edge N, done high in the cycle after edge N+WIDTH.
REQ-026 SHALL accept a start presented during the done cycle; back-to-back throughput is one op per WIDTH+1 cycles.
REQ-027 SHALL handle MTHI/MTLO only in IDLE: write hi or lo from in0 on the accepting edge, with no busy and no done; when busy they SHALL be ignored.
REQ-028 SHALL, on abort during CALC, return to IDLE next edge with hi/lo/div_zero unchanged and no done; abort in IDLE SHALL be a no-op.
REQ-029 SHALL give abort priority over start in the same cycle.
REQ-030 SHALL treat an unlisted op with start as a no-op.

Reset
REQ-031 SHALL, on rst, asynchronously force state IDLE, counter 0, busy 0, done 0, div_zero 0, hi 0, lo 0, internal datapath 0.
REQ-032 SHALL, on rst mid-CALC, discard the result; the first edge after rst release SHALL accept a new start.

Configuration
REQ-033 SHALL use macro MULDIV_SIGNED_EN to compile in signed MULT/DIV support.
REQ-034 SHALL, with MULDIV_SIGNED_EN defined, behave per REQ-019..REQ-021.
REQ-035 SHALL, without MULDIV_SIGNED_EN, execute MULT as MULTU and DIV as DIVU, removing the sign-correction logic; timing SHALL be unchanged.

Verification (WIDTH=32, MULDIV_SIGNED_EN defined unless noted)
REQ-036 SHALL pass: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after accept, busy high for 32 cycles.
REQ-037 SHALL pass: MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; same stimulus without macro -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-038 SHALL pass: DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 SHALL pass: DIVU 7 / 0 -> done one cycle after accept, hi=7, lo=0xFFFFFFFF, div_zero=1; next MULTU 2x3 -> div_zero=0, lo=6.
REQ-040 SHALL pass: MTLO 0x1234 then MULT started, abort at CALC cycle 10, plus start-while-busy -> lo stays 0x1234, no done, busy=0 next cycle.
REQ-041 SHALL pass: rst asserted mid-CALC -> all outputs 0 immediately; back-to-back starts in done cycles -> results every 33 cycles.
